// File: rtl/instr_queue_mw.sv
// rtl/instr_queue_mw.sv - multi-width in-order instruction queue (N-wide enqueue, M-wide dequeue, flush)
module instr_queue_mw #(
   parameter  int WIDTH = 64,
   parameter  int DEPTH = 16,
   parameter  int ENQ_W = 2,
   parameter  int DEQ_W = 2,
   localparam int CNT_W = $clog2(DEPTH + 1),
   localparam int PTR_W = $clog2(DEPTH),
   localparam int EW    = $clog2(ENQ_W + 1),
   localparam int DW    = $clog2(DEQ_W + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   flush,
   input  logic [EW-1:0]          enq_cnt,
   input  logic [ENQ_W*WIDTH-1:0] enq_data,
   output logic                   enq_ready,
   output logic [DEQ_W-1:0]       deq_valid,
   output logic [DEQ_W*WIDTH-1:0] deq_data,
   input  logic [DW-1:0]          deq_cnt,
   output logic [CNT_W-1:0]       count,
   output logic                   full,
   output logic                   empty
);

   logic [WIDTH-1:0] storage [DEPTH];
   logic [PTR_W:0]   head;
   logic [PTR_W:0]   tail;
   logic [CNT_W-1:0] count_q;
   logic [PTR_W-1:0] head_idx;
   logic [PTR_W-1:0] tail_idx;
   logic [EW-1:0]    enq_n;
   logic [DW-1:0]    deq_n;
   logic             enq_acc;
   logic [CNT_W-1:0] enq_add;
   logic [CNT_W-1:0] pop;

   assign head_idx  = head[PTR_W-1:0];
   assign tail_idx  = tail[PTR_W-1:0];
   assign count     = count_q;
   assign empty     = (head == tail);
   assign full      = (head_idx == tail_idx) && (head[PTR_W] != tail[PTR_W]);
   assign enq_ready = (count_q <= CNT_W'(DEPTH - ENQ_W));

   // Read lanes index off the head with natural power-of-two wrap.
   for (genvar i = 0; i < DEQ_W; i++) begin : g_deq
      assign deq_valid[i]                 = (count_q > CNT_W'(i));
      assign deq_data[i*WIDTH +: WIDTH]   = storage[head_idx + PTR_W'(i)];
   end

   // Out-of-range lane counts are clamped so pointers never skip unwritten slots.
   always_comb begin
      enq_n   = (enq_cnt > EW'(ENQ_W)) ? EW'(ENQ_W) : enq_cnt;
      deq_n   = (deq_cnt > DW'(DEQ_W)) ? DW'(DEQ_W) : deq_cnt;
      enq_acc = enq_ready && (enq_n != '0);
      enq_add = enq_acc ? CNT_W'(enq_n) : '0;
      pop     = (CNT_W'(deq_n) > count_q) ? count_q : CNT_W'(deq_n);
   end

   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         head    <= '0;
         tail    <= '0;
         count_q <= '0;
      end else begin
         head    <= head + (PTR_W+1)'(pop);
         tail    <= tail + (PTR_W+1)'(enq_add);
         count_q <= count_q + enq_add - pop;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && !flush && enq_acc) begin
         for (int i = 0; i < ENQ_W; i++) begin
            if (i < int'(enq_n))
               storage[tail_idx + PTR_W'(i)] <= enq_data[i*WIDTH +: WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert (count_q <= CNT_W'(DEPTH))
            else $error("instr_queue_mw: occupancy above depth");
         assert (enq_cnt <= EW'(ENQ_W))
            else $warning("instr_queue_mw: enq_cnt above lane count");
         assert (deq_cnt <= DW'(DEQ_W))
            else $warning("instr_queue_mw: deq_cnt above lane count");
         assert (enq_ready || enq_cnt == '0)
            else $warning("instr_queue_mw: enqueue while not ready, ignored");
         assert (CNT_W'(deq_cnt) <= count_q)
            else $warning("instr_queue_mw: deq_cnt above occupancy, clamped");
         assert (full == (count_q == CNT_W'(DEPTH)))
            else $error("instr_queue_mw: full disagrees with count");
         assert (empty == (count_q == '0))
            else $error("instr_queue_mw: empty disagrees with count");
         assert ((deq_valid & (deq_valid + DEQ_W'(1))) == '0)
            else $error("instr_queue_mw: deq_valid not thermometer coded");
      end
   end

endmodule

// File: tb/tb_instr_queue_mw.sv
// tb/tb_instr_queue_mw.sv - randomized and directed bench for instr_queue_mw against a queue model
module tb_instr_queue_mw;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         flush;
   logic [1:0]   enq_cnt;
   logic [127:0] enq_data;
   logic         enq_ready;
   logic [1:0]   deq_valid;
   logic [127:0] deq_data;
   logic [1:0]   deq_cnt;
   logic [4:0]   count;
   logic         full;
   logic         empty;

   int tests = 0;
   int fails = 0;
   logic [63:0] model_q [$];

   instr_queue_mw dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .flush     (flush),
      .enq_cnt   (enq_cnt),
      .enq_data  (enq_data),
      .enq_ready (enq_ready),
      .deq_valid (deq_valid),
      .deq_data  (deq_data),
      .deq_cnt   (deq_cnt),
      .count     (count),
      .full      (full),
      .empty     (empty)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   // Every visible output is derived from the model queue contents alone.
   task automatic check_outputs(input string tag);
      int n;
      n = model_q.size();
      chk({tag, ".count"}, 64'(count), 64'(n));
      chk({tag, ".empty"}, 64'(empty), 64'(n == 0));
      chk({tag, ".full"}, 64'(full), 64'(n == 16));
      chk({tag, ".enq_ready"}, 64'(enq_ready), 64'((16 - n) >= 2));
      chk({tag, ".deq_valid"}, 64'(deq_valid), 64'({n > 1, n > 0}));
      for (int i = 0; i < 2; i++)
         if (i < n) chk({tag, ".deq_data"}, deq_data[i*64 +: 64], model_q[i]);
   endtask

   // One clock: check current outputs, apply inputs, advance the model, cross the edge.
   task automatic step(input string tag, input logic fl, input int ecnt, input logic [63:0] d0,
                       input logic [63:0] d1, input int dcnt);
      int n;
      int p;
      check_outputs(tag);
      flush    = fl;
      enq_cnt  = ecnt[1:0];
      enq_data = {d1, d0};
      deq_cnt  = dcnt[1:0];
      n = model_q.size();
      if (fl) begin
         model_q.delete();
      end else begin
         p = (dcnt < n) ? dcnt : n;
         for (int i = 0; i < p; i++) void'(model_q.pop_front());
         if ((16 - n) >= 2 && ecnt > 0) begin
            model_q.push_back(d0);
            if (ecnt > 1) model_q.push_back(d1);
         end
      end
      @(negedge clk);
      flush   = 1'b0;
      enq_cnt = '0;
      deq_cnt = '0;
   endtask

   function automatic logic [63:0] ent(input int k);
      return {32'h6000_0000 + 32'(4 * k), 32'(k)};
   endfunction

   initial begin
      int k;
      int dmax;
      rst_n = 1'b0; flush = 1'b0; enq_cnt = '0; deq_cnt = '0; enq_data = '0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_q.delete();

      chk("rst.count", 64'(count), 64'd0);
      chk("rst.deq_valid", 64'(deq_valid), 64'd0);
      for (int i = 0; i < 10; i++) step("idle", 1'b0, 0, '0, '0, 0);

      for (int i = 0; i < 8; i++) step("fill", 1'b0, 2, ent(2*i), ent(2*i+1), 0);
      chk("fill.full", 64'(full), 64'd1);
      chk("fill.enq_ready", 64'(enq_ready), 64'd0);
      for (int i = 0; i < 8; i++) begin
         chk("drain.lane0_pc", 64'(deq_data[63:32]), 64'(32'h6000_0000 + 32'(8 * i)));
         step("drain", 1'b0, 0, '0, '0, 2);
      end
      chk("drain.empty", 64'(empty), 64'd1);

      for (int i = 0; i < 200; i++) begin
         k = (16 - model_q.size() >= 2) ? int'($urandom_range(0, 2)) : 0;
         dmax = (model_q.size() < 2) ? model_q.size() : 2;
         step("rand", 1'b0, k, {$urandom, $urandom}, {$urandom, $urandom},
              int'($urandom_range(0, dmax)));
      end

      step("simul.flush", 1'b1, 0, '0, '0, 0);
      for (int i = 0; i < 7; i++) step("simul.fill", 1'b0, 2, ent(2*i), ent(2*i+1), 0);
      chk("simul.count14", 64'(count), 64'd14);
      step("simul.22", 1'b0, 2, ent(20), ent(21), 2);
      chk("simul.count_stays14", 64'(count), 64'd14);
      step("simul.to15", 1'b0, 1, ent(22), '0, 0);
      chk("simul.count15_ready", 64'(enq_ready), 64'd0);
      step("simul.blocked", 1'b0, 2, ent(23), ent(24), 1);
      chk("simul.count_after_block", 64'(count), 64'd14);

      step("flush.clear", 1'b1, 0, '0, '0, 0);
      for (int i = 0; i < 4; i++) step("flush.fill", 1'b0, 2, ent(30+2*i), ent(31+2*i), 0);
      step("flush.fill1", 1'b0, 1, ent(40), '0, 0);
      chk("flush.count9", 64'(count), 64'd9);
      step("flush.hit", 1'b1, 2, ent(41), ent(42), 2);
      chk("flush.count0", 64'(count), 64'd0);
      chk("flush.deq_valid", 64'(deq_valid), 64'd0);
      chk("flush.enq_ready", 64'(enq_ready), 64'd1);
      step("flush.enq", 1'b0, 1, ent(64), '0, 0);
      chk("flush.lane0_pc", 64'(deq_data[63:32]), 64'h6000_0100);

      step("proto.clear", 1'b1, 0, '0, '0, 0);
      step("proto.one", 1'b0, 1, ent(5), '0, 0);
      step("proto.overpop", 1'b0, 0, '0, '0, 2);
      chk("proto.count0", 64'(count), 64'd0);
      for (int i = 0; i < 8; i++) step("proto.fill", 1'b0, 2, ent(50+2*i), ent(51+2*i), 0);
      step("proto.enq_full", 1'b0, 1, ent(99), '0, 0);
      chk("proto.full_kept", 64'(count), 64'd16);
      check_outputs("final");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
